// File: rtl/montgomery_pkg.sv
// Shared types and helpers for the radix-2 Montgomery multiplier.
package montgomery_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    REDUCE,
    OUT
  } state_t;

  // Quotient bit that makes A + x_i*y + u*m even (m' = 1 for odd m).
  function automatic logic calc_u(input logic a0, input logic x_i, input logic y0);
    return a0 ^ (x_i & y0);
  endfunction

endpackage

// File: rtl/montgomery_iter.sv
// One combinational radix-2 Montgomery iteration: (A + x_i*y + u*m) >> 1.
module montgomery_iter
  import montgomery_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic [WORD_WIDTH+1:0] a,
  input  logic                  x_i,
  input  logic [WORD_WIDTH-1:0] y,
  input  logic [WORD_WIDTH-1:0] m,
  output logic [WORD_WIDTH+1:0] a_next
);

  logic                  u;
  logic [WORD_WIDTH+2:0] sum;
  logic                  unused_lsb;

  // One spare bit above A keeps out-of-range operands from wrapping before the shift.
  always_comb begin
    u      = calc_u(a[0], x_i, y[0]);
    sum    = {1'b0, a}
           + {3'b000, y & {WORD_WIDTH{x_i}}}
           + {3'b000, m & {WORD_WIDTH{u}}};
    a_next = sum[WORD_WIDTH+2:1];
  end

  assign unused_lsb = sum[0];

endmodule

// File: rtl/montgomery_mult_hs.sv
// Radix-2 Montgomery multiplier x*y*2^-WORD_WIDTH mod m with valid/ready on both sides.
module montgomery_mult_hs
  import montgomery_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] m,
  input  logic [WORD_WIDTH-1:0] x,
  input  logic [WORD_WIDTH-1:0] y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  err
);

  localparam logic [CNT_WIDTH-1:0] LastIter = CNT_WIDTH'(WORD_WIDTH - 1);

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] m_q, m_d;
  logic [WORD_WIDTH-1:0] x_q, x_d;
  logic [WORD_WIDTH-1:0] y_q, y_d;
  logic [WORD_WIDTH+1:0] a_q, a_d;
  logic [CNT_WIDTH-1:0]  i_q, i_d;
  logic [WORD_WIDTH-1:0] result_q, result_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  x_bit;
  logic [WORD_WIDTH+1:0] a_iter;
  logic [WORD_WIDTH:0]   a_low;
  logic [WORD_WIDTH:0]   m_ext;
  logic [WORD_WIDTH:0]   diff;
  logic                  a_ge_m;
  logic                  unused_diff_msb;
  logic                  unused_a_msb;

  montgomery_iter #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_iter (
    .a     (a_q),
    .x_i   (x_bit),
    .y     (y_q),
    .m     (m_q),
    .a_next(a_iter)
  );

  // Held low during reset so nothing upstream sees a ready block before release.
  assign in_ready  = reset_n && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == OUT);
  assign result    = result_q;
  assign err       = err_q;

  // Bit i of the captured multiplicand, without a narrow-index select.
  assign x_bit = |(x_q & ({{(WORD_WIDTH - 1){1'b0}}, 1'b1} << i_q));

  // A < 2m at this point, so the final subtraction only needs WORD_WIDTH+1 bits.
  assign a_low  = a_q[WORD_WIDTH:0];
  assign m_ext  = {1'b0, m_q};
  assign diff   = a_low - m_ext;
  assign a_ge_m = (a_low >= m_ext);

  assign unused_diff_msb = diff[WORD_WIDTH];
  assign unused_a_msb    = a_q[WORD_WIDTH+1];

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    x_d      = x_q;
    y_d      = y_q;
    a_d      = a_q;
    i_d      = i_q;
    result_d = result_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          m_d = m;
          x_d = x;
          y_d = y;
          a_d = '0;
          i_d = '0;
          if (!m[0]) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = OUT;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        a_d = a_iter;
        i_d = i_q + CNT_WIDTH'(1);
        if (i_q == LastIter) begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        result_d = a_ge_m ? diff[WORD_WIDTH-1:0] : a_low[WORD_WIDTH-1:0];
        err_d    = 1'b0;
        state_d  = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      a_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      x_q      <= x_d;
      y_q      <= y_d;
      a_q      <= a_d;
      i_q      <= i_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule
